// File: rtl/tm_qm_ll_ctrl.sv
// Linked-list queue manager: per-queue head/tail/depth, shared next-pointer and
// descriptor store, and a free-entry FIFO, driven by a serialising enq/deq FSM.
module tm_qm_ll_ctrl #(
    parameter int QUEUE_ID_NBITS      = 4,
    parameter int QUEUE_ENTRIES_NBITS = 6,
    parameter int DESC_NBITS          = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enq_req,
    input  logic [QUEUE_ID_NBITS-1:0]      enq_qid,
    input  logic [DESC_NBITS-1:0]          enq_desc,
    output logic                           enq_ack,
    output logic                           enq_full,
    input  logic                           deq_req,
    input  logic [QUEUE_ID_NBITS-1:0]      deq_qid,
    output logic                           deq_ack,
    output logic                           deq_empty,
    output logic [DESC_NBITS-1:0]          deq_desc,
    input  logic [QUEUE_ID_NBITS-1:0]      depth_qid,
    output logic [QUEUE_ENTRIES_NBITS:0]   depth_rdata,
    output logic [QUEUE_ENTRIES_NBITS:0]   free_cnt,
    output logic [15:0]                    drop_cnt,
    output logic                           init_done
);

    localparam int NQ = 1 << QUEUE_ID_NBITS;
    localparam int NE = 1 << QUEUE_ENTRIES_NBITS;

    typedef logic [QUEUE_ENTRIES_NBITS-1:0] entry_t;
    typedef logic [QUEUE_ENTRIES_NBITS:0]   count_t;
    typedef logic [QUEUE_ID_NBITS-1:0]      qid_t;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_ENQ,
        ST_DEQ_RD,
        ST_DEQ_RSP
    } state_t;

    localparam entry_t LAST_ENTRY = entry_t'(NE - 1);

    state_t state, state_nxt;

    entry_t head [NQ];
    entry_t tail [NQ];
    count_t depth [NQ];

    entry_t free_fifo [NE];
    entry_t free_rd_ptr;
    entry_t free_wr_ptr;
    entry_t init_idx;

    logic [DESC_NBITS-1:0] desc_mem [NE];
    entry_t                ll_mem [NE];
    logic [DESC_NBITS-1:0] desc_rdata;
    entry_t                ll_rdata;

    logic   prio_deq;
    qid_t   cur_qid;
    logic   deq_was_empty;
    logic   grant_enq;
    logic   grant_deq;
    logic   pool_empty;
    logic   q_empty;
    entry_t new_entry;
    entry_t cur_head;
    logic   enq_commit;
    logic   deq_read;
    logic   deq_commit;

    assign pool_empty = (free_cnt == '0);
    assign q_empty    = (depth[cur_qid] == '0);
    assign new_entry  = free_fifo[free_rd_ptr];
    assign cur_head   = head[cur_qid];
    assign enq_commit = !rst && (state == ST_ENQ) && !pool_empty;
    assign deq_read   = !rst && (state == ST_DEQ_RD) && !q_empty;
    assign deq_commit = !rst && (state == ST_DEQ_RSP) && !deq_was_empty;

    // Round-robin grant: on contention the side not served last wins.
    always_comb begin
        state_nxt = state;
        grant_enq = 1'b0;
        grant_deq = 1'b0;
        case (state)
            ST_INIT: begin
                if (init_idx == LAST_ENTRY) state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                if (enq_req && deq_req) begin
                    grant_deq = prio_deq;
                    grant_enq = !prio_deq;
                end else begin
                    grant_enq = enq_req;
                    grant_deq = deq_req;
                end
                if (grant_enq)      state_nxt = ST_ENQ;
                else if (grant_deq) state_nxt = ST_DEQ_RD;
            end
            ST_ENQ:     state_nxt = ST_IDLE;
            ST_DEQ_RD:  state_nxt = ST_DEQ_RSP;
            ST_DEQ_RSP: state_nxt = ST_IDLE;
            default:    state_nxt = ST_INIT;
        endcase
    end

    always_comb begin
        enq_ack   = (state == ST_ENQ);
        enq_full  = (state == ST_ENQ) && pool_empty;
        deq_ack   = (state == ST_DEQ_RSP);
        deq_empty = (state == ST_DEQ_RSP) && deq_was_empty;
        deq_desc  = '0;
        if ((state == ST_DEQ_RSP) && !deq_was_empty) deq_desc = desc_rdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_INIT;
            init_idx      <= '0;
            free_rd_ptr   <= '0;
            free_wr_ptr   <= '0;
            free_cnt      <= '0;
            drop_cnt      <= '0;
            init_done     <= 1'b0;
            prio_deq      <= 1'b0;
            cur_qid       <= '0;
            deq_was_empty <= 1'b0;
            depth_rdata   <= '0;
            for (int i = 0; i < NQ; i++) begin
                depth[i] <= '0;
                head[i]  <= '0;
                tail[i]  <= '0;
            end
        end else begin
            state       <= state_nxt;
            depth_rdata <= depth[depth_qid];
            case (state)
                ST_INIT: begin
                    init_idx <= init_idx + entry_t'(1);
                    if (init_idx == LAST_ENTRY) begin
                        free_cnt    <= count_t'(NE);
                        init_done   <= 1'b1;
                        free_rd_ptr <= '0;
                        free_wr_ptr <= '0;
                    end
                end
                ST_IDLE: begin
                    if (grant_enq) begin
                        cur_qid  <= enq_qid;
                        prio_deq <= 1'b1;
                    end else if (grant_deq) begin
                        cur_qid  <= deq_qid;
                        prio_deq <= 1'b0;
                    end
                end
                ST_ENQ: begin
                    if (pool_empty) begin
                        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
                    end else begin
                        free_rd_ptr    <= free_rd_ptr + entry_t'(1);
                        free_cnt       <= free_cnt - count_t'(1);
                        depth[cur_qid] <= depth[cur_qid] + count_t'(1);
                        tail[cur_qid]  <= new_entry;
                        if (q_empty) head[cur_qid] <= new_entry;
                    end
                end
                ST_DEQ_RD: begin
                    deq_was_empty <= q_empty;
                end
                ST_DEQ_RSP: begin
                    if (!deq_was_empty) begin
                        head[cur_qid]  <= ll_rdata;
                        depth[cur_qid] <= depth[cur_qid] - count_t'(1);
                        free_wr_ptr    <= free_wr_ptr + entry_t'(1);
                        free_cnt       <= free_cnt + count_t'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Free FIFO storage: seeded with every index during INIT, refilled by dequeues.
    always_ff @(posedge clk) begin
        if (!rst && (state == ST_INIT)) free_fifo[init_idx] <= init_idx;
        else if (deq_commit)            free_fifo[free_wr_ptr] <= cur_head;
    end

    // Appending to a non-empty queue links the old tail to the new entry.
    always_ff @(posedge clk) begin
        if (enq_commit) begin
            desc_mem[new_entry] <= enq_desc;
            if (!q_empty) ll_mem[tail[cur_qid]] <= new_entry;
        end
        if (deq_read) begin
            desc_rdata <= desc_mem[cur_head];
            ll_rdata   <= ll_mem[cur_head];
        end
    end

endmodule

// File: tb/tb_tm_qm_ll_ctrl.sv
// Directed and model-checked bench for tm_qm_ll_ctrl (default parameters:
// 16 queues, 64 entries, 32-bit descriptors).
module tb_tm_qm_ll_ctrl;

    localparam int NQ = 16;
    localparam int NE = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        enq_req;
    logic [3:0]  enq_qid;
    logic [31:0] enq_desc;
    logic        enq_ack;
    logic        enq_full;
    logic        deq_req;
    logic [3:0]  deq_qid;
    logic        deq_ack;
    logic        deq_empty;
    logic [31:0] deq_desc;
    logic [3:0]  depth_qid;
    logic [6:0]  depth_rdata;
    logic [6:0]  free_cnt;
    logic [15:0] drop_cnt;
    logic        init_done;

    int checks   = 0;
    int failures = 0;

    tm_qm_ll_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .enq_req     (enq_req),
        .enq_qid     (enq_qid),
        .enq_desc    (enq_desc),
        .enq_ack     (enq_ack),
        .enq_full    (enq_full),
        .deq_req     (deq_req),
        .deq_qid     (deq_qid),
        .deq_ack     (deq_ack),
        .deq_empty   (deq_empty),
        .deq_desc    (deq_desc),
        .depth_qid   (depth_qid),
        .depth_rdata (depth_rdata),
        .free_cnt    (free_cnt),
        .drop_cnt    (drop_cnt),
        .init_done   (init_done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One enqueue or dequeue handshake; entered and left at #1 after an edge with the FSM idle.
    task automatic applyStimulus(input bit is_deq, input logic [3:0] qid, input logic [31:0] desc,
                                 output bit flag, output logic [31:0] rdesc, output int lat);
        bit seen;
        seen  = 1'b0;
        flag  = 1'b0;
        rdesc = '0;
        lat   = 0;
        if (is_deq) begin
            deq_qid = qid;
            deq_req = 1'b1;
        end else begin
            enq_qid  = qid;
            enq_desc = desc;
            enq_req  = 1'b1;
        end
        while (!seen && lat < 16) begin
            @(posedge clk); #1;
            lat++;
            if (is_deq && deq_ack) begin
                seen  = 1'b1;
                flag  = deq_empty;
                rdesc = deq_desc;
            end else if (!is_deq && enq_ack) begin
                seen = 1'b1;
                flag = enq_full;
            end
        end
        if (is_deq) checkOutput("deq_ack_seen", 64'(seen), 64'd1);
        else        checkOutput("enq_ack_seen", 64'(seen), 64'd1);
        @(posedge clk); #1;
        enq_req = 1'b0;
        deq_req = 1'b0;
    endtask

    task automatic read_depth(input logic [3:0] qid, output logic [6:0] d);
        depth_qid = qid;
        @(posedge clk); #1;
        d = depth_rdata;
    endtask

    task automatic wait_init(output int cycles, output int acks);
        cycles = 0;
        acks   = 0;
        while (!init_done && cycles < 200) begin
            @(posedge clk); #1;
            cycles++;
            if (enq_ack || deq_ack) acks++;
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit          flag;
        logic [31:0] rdesc;
        int          lat;
        int          cyc;
        int          acks;
        logic [6:0]  d;
        logic [31:0] dvec [3];
        logic [9:0]  enq_mask;
        logic [9:0]  deq_mask;
        logic [31:0] got [2];
        int          ngot;
        bit          bump;
        int          nfull;
        logic [31:0] mdata [NQ][NE];
        int          mhead [NQ];
        int          mcnt [NQ];
        int          mtotal;
        logic [3:0]  q;
        logic [31:0] rd;
        int          dsum;

        rst       = 1'b1;
        enq_req   = 1'b0;
        enq_qid   = '0;
        enq_desc  = '0;
        deq_req   = 1'b0;
        deq_qid   = '0;
        depth_qid = '0;

        // Reset values and initialisation length
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_enq_ack", 64'(enq_ack), 64'd0);
        checkOutput("rst_enq_full", 64'(enq_full), 64'd0);
        checkOutput("rst_deq_ack", 64'(deq_ack), 64'd0);
        checkOutput("rst_deq_empty", 64'(deq_empty), 64'd0);
        checkOutput("rst_deq_desc", 64'(deq_desc), 64'd0);
        checkOutput("rst_free_cnt", 64'(free_cnt), 64'd0);
        checkOutput("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        checkOutput("rst_depth_rdata", 64'(depth_rdata), 64'd0);
        checkOutput("rst_init_done", 64'(init_done), 64'd0);
        rst = 1'b0;
        wait_init(cyc, acks);
        checkOutput("init_cycles", 64'(cyc), 64'd64);
        checkOutput("init_free_cnt", 64'(free_cnt), 64'd64);
        for (int i = 0; i < NQ; i++) begin
            read_depth(4'(i), d);
            checkOutput("init_depth", 64'(d), 64'd0);
        end

        // FIFO order on queue 3
        $display("[TB] queue 3 ordering");
        dvec[0] = 32'hA5A5_0000;
        dvec[1] = 32'h5A5A_1111;
        dvec[2] = 32'hDEAD_BEEF;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 4'd3, dvec[k], flag, rdesc, lat);
            checkOutput("q3_enq_full", 64'(flag), 64'd0);
            checkOutput("q3_enq_latency", 64'(lat), 64'd1);
        end
        read_depth(4'd3, d);
        checkOutput("q3_depth3", 64'(d), 64'd3);
        checkOutput("q3_free61", 64'(free_cnt), 64'd61);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 4'd3, '0, flag, rdesc, lat);
            checkOutput("q3_deq_empty", 64'(flag), 64'd0);
            checkOutput("q3_deq_desc", 64'(rdesc), 64'(dvec[k]));
            checkOutput("q3_deq_latency", 64'(lat), 64'd2);
        end
        read_depth(4'd3, d);
        checkOutput("q3_depth0", 64'(d), 64'd0);
        checkOutput("q3_free64", 64'(free_cnt), 64'd64);
        applyStimulus(1'b1, 4'd3, '0, flag, rdesc, lat);
        checkOutput("q3_4th_empty", 64'(flag), 64'd1);
        checkOutput("q3_4th_desc", 64'(rdesc), 64'd0);
        checkOutput("q3_4th_latency", 64'(lat), 64'd2);

        // Contention on queue 1: preload A1, then a dequeue so enqueue is favoured next
        $display("[TB] round-robin contention");
        applyStimulus(1'b0, 4'd1, 32'h0000_00A1, flag, rdesc, lat);
        applyStimulus(1'b1, 4'd0, '0, flag, rdesc, lat);
        checkOutput("rr_q0_empty", 64'(flag), 64'd1);
        enq_qid  = 4'd1;
        enq_desc = 32'h0000_00E0;
        deq_qid  = 4'd1;
        enq_req  = 1'b1;
        deq_req  = 1'b1;
        enq_mask = '0;
        deq_mask = '0;
        ngot     = 0;
        bump     = 1'b0;
        for (int i = 0; i < 10; i++) begin
            enq_mask[i] = enq_ack;
            deq_mask[i] = deq_ack;
            if (deq_ack && ngot < 2) begin
                got[ngot] = deq_desc;
                ngot++;
            end
            bump = enq_ack;
            @(posedge clk); #1;
            if (bump) enq_desc = 32'h0000_00E1;
        end
        enq_req = 1'b0;
        deq_req = 1'b0;
        checkOutput("rr_enq_ack_cycles", 64'(enq_mask), 64'h042);
        checkOutput("rr_deq_ack_cycles", 64'(deq_mask), 64'h210);
        checkOutput("rr_deq_count", 64'(ngot), 64'd2);
        checkOutput("rr_deq_desc0", 64'(got[0]), 64'h0A1);
        checkOutput("rr_deq_desc1", 64'(got[1]), 64'h0E0);
        read_depth(4'd1, d);
        checkOutput("rr_q1_depth", 64'(d), 64'd1);
        checkOutput("rr_free63", 64'(free_cnt), 64'd63);
        applyStimulus(1'b1, 4'd1, '0, flag, rdesc, lat);
        checkOutput("rr_drain_desc", 64'(rdesc), 64'h0E1);
        checkOutput("rr_drain_free64", 64'(free_cnt), 64'd64);

        // Fill the whole pool, then one more enqueue must be dropped
        $display("[TB] pool exhaustion");
        nfull = 0;
        for (int i = 0; i < NE; i++) begin
            applyStimulus(1'b0, 4'(i % NQ), 32'h1000 + 32'(i), flag, rdesc, lat);
            if (flag) nfull++;
        end
        checkOutput("fill_no_full", 64'(nfull), 64'd0);
        checkOutput("fill_free0", 64'(free_cnt), 64'd0);
        applyStimulus(1'b0, 4'd7, 32'hDEAD_0065, flag, rdesc, lat);
        checkOutput("fill_65th_full", 64'(flag), 64'd1);
        checkOutput("fill_drop_cnt", 64'(drop_cnt), 64'd1);
        checkOutput("fill_free_still0", 64'(free_cnt), 64'd0);
        read_depth(4'd7, d);
        checkOutput("fill_q7_depth", 64'(d), 64'd4);
        read_depth(4'd0, d);
        checkOutput("fill_q0_depth", 64'(d), 64'd4);

        // Reset while a dequeue of queue 5 (depth 4) is in DEQ_RD
        $display("[TB] reset during dequeue");
        read_depth(4'd5, d);
        checkOutput("mid_q5_depth4", 64'(d), 64'd4);
        deq_qid = 4'd5;
        deq_req = 1'b1;
        @(posedge clk); #1;
        rst     = 1'b1;
        deq_req = 1'b0;
        @(posedge clk); #1;
        checkOutput("mid_no_deq_ack", 64'(deq_ack), 64'd0);
        checkOutput("mid_init_done_low", 64'(init_done), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        wait_init(cyc, acks);
        checkOutput("mid_init_cycles", 64'(cyc), 64'd64);
        checkOutput("mid_no_acks", 64'(acks), 64'd0);
        read_depth(4'd5, d);
        checkOutput("mid_q5_depth0", 64'(d), 64'd0);
        checkOutput("mid_free64", 64'(free_cnt), 64'd64);
        checkOutput("mid_drop0", 64'(drop_cnt), 64'd0);

        // Random interleaved traffic against a per-queue FIFO model
        $display("[TB] random traffic");
        for (int i = 0; i < NQ; i++) begin
            mhead[i] = 0;
            mcnt[i]  = 0;
        end
        mtotal = 0;
        for (int n = 0; n < 200; n++) begin
            q = 4'($urandom_range(0, NQ - 1));
            if ($urandom_range(0, 99) < 60) begin
                rd = $urandom;
                applyStimulus(1'b0, q, rd, flag, rdesc, lat);
                checkOutput("rnd_enq_full", 64'(flag), (mtotal == NE) ? 64'd1 : 64'd0);
                if (mtotal < NE) begin
                    mdata[q][(mhead[q] + mcnt[q]) % NE] = rd;
                    mcnt[q]++;
                    mtotal++;
                end
            end else begin
                applyStimulus(1'b1, q, '0, flag, rdesc, lat);
                if (mcnt[q] == 0) begin
                    checkOutput("rnd_deq_empty", 64'(flag), 64'd1);
                    checkOutput("rnd_deq_desc0", 64'(rdesc), 64'd0);
                end else begin
                    checkOutput("rnd_deq_empty", 64'(flag), 64'd0);
                    checkOutput("rnd_deq_desc", 64'(rdesc), 64'(mdata[q][mhead[q]]));
                    mhead[q] = (mhead[q] + 1) % NE;
                    mcnt[q]--;
                    mtotal--;
                end
            end
            checkOutput("rnd_free_cnt", 64'(free_cnt), 64'(NE - mtotal));
        end
        dsum = 0;
        for (int i = 0; i < NQ; i++) begin
            read_depth(4'(i), d);
            checkOutput("rnd_depth", 64'(d), 64'(mcnt[i]));
            dsum += int'(d);
        end
        checkOutput("rnd_invariant", 64'(dsum + int'(free_cnt)), 64'd64);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tm_qm_ll_ctrl.md
# tm_qm_ll_ctrl

Parametrised linked-list queue manager for the traffic-manager scheduler. It owns per-queue head, tail and depth state, a per-entry next-pointer and descriptor store, and a free-entry FIFO. It serialises enqueue and dequeue requests through a small FSM, arbitrating between them round-robin. It sits between the scheduler's enqueue/dequeue engines and replaces direct, uncoordinated access to raw queue data-structure memories.

## Interface
- QUEUE_ID_NBITS, 4: log2 of queue count; NQ = 2^QUEUE_ID_NBITS.
- QUEUE_ENTRIES_NBITS, 6: log2 of shared entry pool; NE = 2^QUEUE_ENTRIES_NBITS.
- DESC_NBITS, 32: descriptor width.
- clk  in  1  single clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- enq_req  in  1  enqueue request; held until enq_ack.
- enq_qid  in  QUEUE_ID_NBITS  target queue.
- enq_desc  in  DESC_NBITS  descriptor to store.
- enq_ack  out  1  one-cycle accept/complete pulse.
- enq_full  out  1  valid with enq_ack; 1 = pool empty, request dropped.
- deq_req  in  1  dequeue request; held until deq_ack.
- deq_qid  in  QUEUE_ID_NBITS  source queue.
- deq_ack  out  1  one-cycle completion pulse.
- deq_empty  out  1  valid with deq_ack; 1 = queue was empty.
- deq_desc  out  DESC_NBITS  head descriptor, valid with deq_ack; 0 when deq_empty.
- depth_qid  in  QUEUE_ID_NBITS  depth query address.
- depth_rdata  out  QUEUE_ENTRIES_NBITS+1  depth of depth_qid, registered, 1-cycle latency.
- free_cnt  out  QUEUE_ENTRIES_NBITS+1  free entries in pool.
- drop_cnt  out  16  enqueue drops, saturating at 0xFFFF.
- init_done  out  1  high once free FIFO initialisation completes.

## Operation
- Storage: head, tail and depth register arrays of NQ entries. Next-pointer (ll) and descriptor RAMs of NE entries with 1-cycle registered read. Free FIFO of NE entry indices with rd/wr pointers, wrapping modulo NE.
- FSM states: INIT, IDLE, ENQ, DEQ_RD, DEQ_RSP.
- INIT: writes free FIFO slot i = i for i = 0..NE-1, one slot per cycle. Then sets free_cnt = NE and init_done = 1, and moves to IDLE. Requests are ignored in INIT.
- IDLE: samples requests.
  - Both requests high: grant goes to the side not granted last. The priority bit resets to favour enqueue.
  - Only one high: that side is granted.
  - Enqueue grant goes to ENQ; dequeue grant goes to DEQ_RD.
- ENQ:
  - If free_cnt == 0: assert enq_ack with enq_full = 1 and increment drop_cnt. No other state changes.
  - Otherwise pop entry e and write desc[e] = enq_desc.
    - If depth[q] == 0: head[q] = tail[q] = e.
    - Else: ll[tail[q]] = e, then tail[q] = e.
    - depth[q]++, free_cnt--, enq_ack = 1, enq_full = 0.
  - Returns to IDLE.
- DEQ_RD:
  - If depth[q] == 0: go to DEQ_RSP flagged empty.
  - Else: issue reads of desc[head[q]] and ll[head[q]].
- DEQ_RSP:
  - Empty case: deq_ack = 1, deq_empty = 1, deq_desc = 0.
  - Otherwise: deq_desc = RAM data, head[q] = ll data, depth[q]--, push old head to free FIFO, free_cnt++, deq_ack = 1.
  - When depth reaches 0, head and tail are left stale and are overwritten by the next enqueue.
  - Returns to IDLE.
- The qid is latched at grant. Changes on enq_qid or deq_qid after grant have no effect.
- Invariant: sum of depth[] + free_cnt == NE at all times outside INIT.

## Timing
- Reset values:
  - enq_ack, enq_full, deq_ack, deq_empty, init_done = 0.
  - deq_desc, free_cnt, drop_cnt, depth_rdata = 0.
  - All depth[] = 0, priority favours enqueue, FSM = INIT.
- rst asserted at any time, including mid-operation, aborts the operation with no ack issued, empties all queues and re-runs INIT.
- INIT lasts NE cycles after rst deasserts. init_done rises in the first IDLE cycle.
- Request seen in IDLE at cycle T:
  - enq_ack in cycle T+1.
  - deq_ack in cycle T+2.
- Maximum throughput: one enqueue per 2 cycles, one dequeue per 3 cycles.
- Acks are Moore outputs and last exactly 1 cycle. The requester changes or drops its request in the cycle after the ack; the FSM is back in IDLE that cycle.
- depth_rdata reflects state after any update committed on the same edge: depth updated at edge T is visible when queried in cycle T+1.

## Test plan
- Reset then idle: init_done rises NE cycles after rst falls; free_cnt = 64 (defaults); all depth_rdata = 0.
- Enqueue D0..D2 to queue 3, then dequeue 3 times: deq_desc = D0, D1, D2 in order; depth 3→0; free_cnt returns to 64; a 4th dequeue gives deq_empty = 1, deq_desc = 0.
- Simultaneous held enq_req (q1) and deq_req (q1, non-empty) for 10 cycles: grants alternate enq, deq, enq, …; acks at the stated latencies.
- Fill the pool with 64 enqueues spread across queues 0..15; the 65th gives enq_full = 1 and drop_cnt = 1; free_cnt stays 0; depths are unchanged.
- Interleaved FIFO wrap: 200 random enq/deq operations across 16 queues against a reference model; every descriptor matches; the invariant sum(depth) + free_cnt = 64 is checked each cycle.
- Assert rst during DEQ_RD with queue 5 at depth 4: no deq_ack; INIT re-runs; depth[5] = 0; free_cnt = 64; drop_cnt = 0.
